aq_mmu_sysmap_ctrl: RTL and testbench
=====================================

// Module: aq_mmu_sysmap_ctrl
// PURPOSE
//  Request/response front end for the sysmap attribute lookup in the PTW-refill -> TLB-write path.
//  Accepts refill PPNs with valid/ready, drives the combinational sysmap lookup, registers the
//  5-bit attribute flags and returns PPN+flags downstream with valid/ready.
//  Holds a 1-entry last-lookup cache, so back-to-back refills of the same PPN skip the lookup.
//  A flush clears in-flight state; it is used on sfence and on a sysmap region rewrite.
// PARAMETERS
//  PPN_WIDTH  28  physical page number width, PA[39:12]
//  FLG_WIDTH  5   sysmap flag width {SO,C,B,SH,SEC}; no-hit default 5'b10011
// PORTS
//  forever_cpuclk   in   1          core clock
//  cpurst           in   1          async reset, active-high
//  ptw_ctrl_vld     in   1          refill request valid
//  ptw_ctrl_ppn     in   PPN_WIDTH  refill PPN
//  ctrl_ptw_rdy     out  1          request accepted when vld&rdy
//  mmu_sysmap_pa    out  PPN_WIDTH  lookup address to sysmap (combinational from req reg)
//  sysmap_mmu_flg   in   FLG_WIDTH  sysmap result, same-cycle combinational return
//  ctrl_tlb_vld     out  1          response valid
//  ctrl_tlb_ppn     out  PPN_WIDTH  response PPN
//  ctrl_tlb_flg     out  FLG_WIDTH  response flags
//  tlb_ctrl_rdy     in   1          downstream ready
//  ctrl_flush       in   1          kill in-flight request, invalidate cache
//  ctrl_cache_hit   out  1          1-cycle pulse: accepted request served from cache
// BEHAVIOUR
//  Reset: all regs 0; FSM=IDLE; ctrl_ptw_rdy=1, ctrl_tlb_vld=0, ctrl_tlb_ppn=0, ctrl_tlb_flg=0,
//   mmu_sysmap_pa=0, ctrl_cache_hit=0, cache_vld=0.
//  FSM states: IDLE, LOOKUP, RESP.
//  IDLE, handshake, PPN == cache_ppn and cache_vld: go to RESP with the cached flags next cycle;
//   pulse ctrl_cache_hit. Latency is 1 cycle.
//  IDLE, handshake, cache miss: latch the PPN into req_ppn and go to LOOKUP.
//  LOOKUP: mmu_sysmap_pa=req_ppn; capture sysmap_mmu_flg into resp_flg and into the cache
//   (cache_ppn<=req_ppn, cache_vld<=1); go to RESP. Latency is 2 cycles.
//  RESP: ctrl_tlb_vld=1; ppn/flg stay stable until tlb_ctrl_rdy. On handshake, go to IDLE.
//   No accept in the handshake cycle, so there is at most 1 request outstanding.
//  ctrl_ptw_rdy = (state==IDLE) & ~ctrl_flush.
//  mmu_sysmap_pa is driven from req_ppn in all states. It is never driven from the raw input,
//   which keeps the compare chain off the PTW path.
//  Flush, any state: next state IDLE; ctrl_tlb_vld is 0 next cycle; cache_vld<=0; no request is
//   accepted in the flush cycle.
//  Flush in LOOKUP: the result is discarded and the cache is NOT written.
//  Flush has priority over every simultaneous handshake; a response handshaken in the flush
//   cycle is still taken by TLB, because vld was 1 that cycle.
//  Reset mid-operation: async return to the reset values; a partial response is never presented.
//  PPN is compared across all PPN_WIDTH bits with no masking.
//  Flags are passed through unmodified; the no-hit default is produced by sysmap, not here.
// STRUCTURE
//  Shared package/header (mmu defines): PPN_WIDTH, FLG_WIDTH, SYSMAP_FLG_DEFAULT=5'b10011,
//   FSM encodings IDLE=2'b00, LOOKUP=2'b01, RESP=2'b10.
//  Instantiates the existing sysmap lookup module at the mmu top level, not inside this block.
//  One natural sub-module, aq_mmu_sysmap_cache: 1-entry PPN/flag store with write, invalidate
//   and a compare-hit output.
// TESTING
//  Miss: PPN 28'h0080000, sysmap returns 5'b01110 -> vld in cycle 2 with ppn 28'h0080000,
//   flg 5'b01110; hit pulse 0.
//  Same PPN again after the handshake -> vld 1 cycle after accept, flg 5'b01110, hit pulse 1,
//   mmu_sysmap_pa unchanged.
//  Backpressure: tlb_ctrl_rdy=0 for 5 cycles -> vld, ppn, flg stable; ctrl_ptw_rdy=0 throughout.
//  Flush in LOOKUP -> no vld; the same PPN next is a miss (2-cycle latency, hit pulse 0).
//  Flush together with ptw_ctrl_vld in IDLE -> request is not accepted (rdy=0), state IDLE.
//  Assert cpurst during RESP -> vld=0 immediately, cache_vld=0, rdy=1 after release.

Source files
------------

// File: rtl/aq_mmu_sysmap_ctrl_pkg.sv
// Shared mmu sysmap definitions: widths, no-hit flag default and the front-end FSM encoding.
package aq_mmu_sysmap_ctrl_pkg;

    localparam int PPN_WIDTH = 28;
    localparam int FLG_WIDTH = 5;

    // {SO,C,B,SH,SEC} returned by sysmap when no region matches
    localparam logic [FLG_WIDTH-1:0] SYSMAP_FLG_DEFAULT = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_RESP   = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/aq_mmu_sysmap_cache.sv
// Single-entry PPN -> sysmap flag store; write on lookup completion, invalidate wins over write.
// Hit is a full-width PPN compare qualified by the valid bit, available combinationally.
module aq_mmu_sysmap_cache
    import aq_mmu_sysmap_ctrl_pkg::*;
#(
    parameter int PPN_WIDTH = aq_mmu_sysmap_ctrl_pkg::PPN_WIDTH,
    parameter int FLG_WIDTH = aq_mmu_sysmap_ctrl_pkg::FLG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [PPN_WIDTH-1:0] i_wr_ppn,
    input  logic [FLG_WIDTH-1:0] i_wr_flg,
    input  logic                 i_inv,
    input  logic [PPN_WIDTH-1:0] i_cmp_ppn,
    output logic                 o_hit,
    output logic [FLG_WIDTH-1:0] o_flg
);

    logic                 r_vld;
    logic [PPN_WIDTH-1:0] r_ppn;
    logic [FLG_WIDTH-1:0] r_flg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_ppn <= '0;
            r_flg <= '0;
        end else if (i_inv) begin
            r_vld <= 1'b0;
        end else if (i_wr) begin
            r_vld <= 1'b1;
            r_ppn <= i_wr_ppn;
            r_flg <= i_wr_flg;
        end
    end

    assign o_hit = r_vld & (r_ppn == i_cmp_ppn);
    assign o_flg = r_flg;

endmodule

// File: rtl/aq_mmu_sysmap_ctrl.sv
// Sysmap attribute front end between PTW refill and TLB write; one request outstanding.
// Latency: 1 cycle on cache hit, 2 on miss. Response held stable until tlb_ctrl_rdy; flush kills all.
module aq_mmu_sysmap_ctrl
    import aq_mmu_sysmap_ctrl_pkg::*;
#(
    parameter int PPN_WIDTH = aq_mmu_sysmap_ctrl_pkg::PPN_WIDTH,
    parameter int FLG_WIDTH = aq_mmu_sysmap_ctrl_pkg::FLG_WIDTH
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 ptw_ctrl_vld,
    input  logic [PPN_WIDTH-1:0] ptw_ctrl_ppn,
    output logic                 ctrl_ptw_rdy,
    output logic [PPN_WIDTH-1:0] mmu_sysmap_pa,
    input  logic [FLG_WIDTH-1:0] sysmap_mmu_flg,
    output logic                 ctrl_tlb_vld,
    output logic [PPN_WIDTH-1:0] ctrl_tlb_ppn,
    output logic [FLG_WIDTH-1:0] ctrl_tlb_flg,
    input  logic                 tlb_ctrl_rdy,
    input  logic                 ctrl_flush,
    output logic                 ctrl_cache_hit
);

    ctrl_state_e          r_state;
    ctrl_state_e          w_state_nxt;
    logic [PPN_WIDTH-1:0] r_req_ppn;
    logic [PPN_WIDTH-1:0] r_resp_ppn;
    logic [FLG_WIDTH-1:0] r_resp_flg;
    logic                 r_hit;

    logic                 w_req_hs;
    logic                 w_cache_hit;
    logic                 w_hit_hs;
    logic                 w_lookup_done;
    logic [FLG_WIDTH-1:0] w_cache_flg;

    assign ctrl_ptw_rdy  = (r_state == ST_IDLE) & ~ctrl_flush;
    assign w_req_hs      = ptw_ctrl_vld & ctrl_ptw_rdy;
    assign w_hit_hs      = w_req_hs & w_cache_hit;
    assign w_lookup_done = (r_state == ST_LOOKUP) & ~ctrl_flush;

    aq_mmu_sysmap_cache #(
        .PPN_WIDTH (PPN_WIDTH),
        .FLG_WIDTH (FLG_WIDTH)
    ) u_cache (
        .clk       (forever_cpuclk),
        .rst       (cpurst),
        .i_wr      (w_lookup_done),
        .i_wr_ppn  (r_req_ppn),
        .i_wr_flg  (sysmap_mmu_flg),
        .i_inv     (ctrl_flush),
        .i_cmp_ppn (ptw_ctrl_ppn),
        .o_hit     (w_cache_hit),
        .o_flg     (w_cache_flg)
    );

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_req_hs) w_state_nxt = w_cache_hit ? ST_RESP : ST_LOOKUP;
            ST_LOOKUP: w_state_nxt = ST_RESP;
            ST_RESP:   if (tlb_ctrl_rdy) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (ctrl_flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // A hit leaves r_req_ppn alone so the sysmap address does not toggle
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_req_ppn  <= '0;
            r_resp_ppn <= '0;
            r_resp_flg <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_hit <= w_hit_hs;
            if (w_hit_hs) begin
                r_resp_ppn <= ptw_ctrl_ppn;
                r_resp_flg <= w_cache_flg;
            end else if (w_req_hs) begin
                r_req_ppn <= ptw_ctrl_ppn;
            end
            if (w_lookup_done) begin
                r_resp_ppn <= r_req_ppn;
                r_resp_flg <= sysmap_mmu_flg;
            end
        end
    end

    assign mmu_sysmap_pa  = r_req_ppn;
    assign ctrl_tlb_vld   = (r_state == ST_RESP);
    assign ctrl_tlb_ppn   = r_resp_ppn;
    assign ctrl_tlb_flg   = r_resp_flg;
    assign ctrl_cache_hit = r_hit;

endmodule

// File: tb/tb_aq_mmu_sysmap_ctrl.sv
// Directed vector bench for aq_mmu_sysmap_ctrl with a small behavioural sysmap region table.
module tb_aq_mmu_sysmap_ctrl;
    import aq_mmu_sysmap_ctrl_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 ptw_vld;
    logic [PPN_WIDTH-1:0] ptw_ppn;
    logic                 ptw_rdy;
    logic [PPN_WIDTH-1:0] sys_pa;
    logic [FLG_WIDTH-1:0] sys_flg;
    logic                 tlb_vld;
    logic [PPN_WIDTH-1:0] tlb_ppn;
    logic [FLG_WIDTH-1:0] tlb_flg;
    logic                 tlb_rdy;
    logic                 flush;
    logic                 hit;

    int checks = 0;
    int errors = 0;

    aq_mmu_sysmap_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .ptw_ctrl_vld   (ptw_vld),
        .ptw_ctrl_ppn   (ptw_ppn),
        .ctrl_ptw_rdy   (ptw_rdy),
        .mmu_sysmap_pa  (sys_pa),
        .sysmap_mmu_flg (sys_flg),
        .ctrl_tlb_vld   (tlb_vld),
        .ctrl_tlb_ppn   (tlb_ppn),
        .ctrl_tlb_flg   (tlb_flg),
        .tlb_ctrl_rdy   (tlb_rdy),
        .ctrl_flush     (flush),
        .ctrl_cache_hit (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [PPN_WIDTH-1:0] PA0 = 28'h0080000;
    localparam logic [PPN_WIDTH-1:0] PA1 = 28'h0123456;
    localparam logic [PPN_WIDTH-1:0] PA2 = 28'h0123457;
    localparam logic [FLG_WIDTH-1:0] F0  = 5'b01110;
    localparam logic [FLG_WIDTH-1:0] F1  = 5'b00101;

    // Sysmap region table, combinational like the real lookup
    always_comb begin
        case (sys_pa)
            PA0:     sys_flg = F0;
            PA1:     sys_flg = F1;
            default: sys_flg = SYSMAP_FLG_DEFAULT;
        endcase
    end

    typedef struct {
        logic                 vld;
        logic [PPN_WIDTH-1:0] ppn;
        logic                 trdy;
        logic                 fl;
        logic                 e_prdy;
        logic                 e_tvld;
        logic [PPN_WIDTH-1:0] e_tppn;
        logic [FLG_WIDTH-1:0] e_tflg;
        logic                 e_hit;
        logic [PPN_WIDTH-1:0] e_pa;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [PPN_WIDTH-1:0] p, input logic tr, input logic f,
                       input logic eprdy, input logic etvld, input logic [PPN_WIDTH-1:0] etppn,
                       input logic [FLG_WIDTH-1:0] etflg, input logic ehit,
                       input logic [PPN_WIDTH-1:0] epa);
        vec_t r;
        r.vld = v; r.ppn = p; r.trdy = tr; r.fl = f;
        r.e_prdy = eprdy; r.e_tvld = etvld; r.e_tppn = etppn; r.e_tflg = etflg;
        r.e_hit = ehit; r.e_pa = epa;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic eprdy, input logic etvld,
                           input logic [PPN_WIDTH-1:0] etppn, input logic [FLG_WIDTH-1:0] etflg,
                           input logic ehit, input logic [PPN_WIDTH-1:0] epa);
        chk("ptw_rdy", row, 32'(ptw_rdy), 32'(eprdy));
        chk("tlb_vld", row, 32'(tlb_vld), 32'(etvld));
        chk("tlb_ppn", row, 32'(tlb_ppn), 32'(etppn));
        chk("tlb_flg", row, 32'(tlb_flg), 32'(etflg));
        chk("cache_hit", row, 32'(hit), 32'(ehit));
        chk("sysmap_pa", row, 32'(sys_pa), 32'(epa));
    endtask

    initial begin
        rst = 1'b0; ptw_vld = 1'b0; ptw_ppn = '0; tlb_rdy = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all(-1, 1'b1, 1'b0, '0, '0, 1'b0, '0);

        //   vld ppn  trdy fl | prdy tvld tppn tflg hit pa
        add(0, 0,   0, 0,  1, 0, 0,   0,  0, 0);    // 0 idle after reset
        add(1, PA0, 1, 0,  1, 0, 0,   0,  0, 0);    // 1 accept, miss
        add(0, 0,   1, 0,  0, 0, 0,   0,  0, PA0);  // 2 lookup
        add(0, 0,   1, 0,  0, 1, PA0, F0, 0, PA0);  // 3 resp, handshake
        add(1, PA0, 0, 0,  1, 0, PA0, F0, 0, PA0);  // 4 accept, hit
        add(0, 0,   0, 0,  0, 1, PA0, F0, 1, PA0);  // 5 resp from cache, backpressure
        add(1, PA1, 0, 0,  0, 1, PA0, F0, 0, PA0);  // 6
        add(1, PA1, 0, 0,  0, 1, PA0, F0, 0, PA0);  // 7
        add(1, PA1, 0, 0,  0, 1, PA0, F0, 0, PA0);  // 8
        add(1, PA1, 0, 0,  0, 1, PA0, F0, 0, PA0);  // 9
        add(0, 0,   1, 0,  0, 1, PA0, F0, 0, PA0);  // 10 release
        add(1, PA1, 0, 0,  1, 0, PA0, F0, 0, PA0);  // 11 accept PA1, miss
        add(0, 0,   0, 1,  0, 0, PA0, F0, 0, PA1);  // 12 flush in lookup
        add(0, 0,   0, 0,  1, 0, PA0, F0, 0, PA1);  // 13 result discarded
        add(1, PA0, 0, 0,  1, 0, PA0, F0, 0, PA1);  // 14 PA0 now misses
        add(0, 0,   1, 0,  0, 0, PA0, F0, 0, PA0);  // 15 lookup
        add(0, 0,   1, 0,  0, 1, PA0, F0, 0, PA0);  // 16 resp, handshake
        add(1, PA0, 0, 1,  0, 0, PA0, F0, 0, PA0);  // 17 flush + vld in idle: refused
        add(1, PA0, 0, 0,  1, 0, PA0, F0, 0, PA0);  // 18 cache invalidated -> miss
        add(0, 0,   1, 0,  0, 0, PA0, F0, 0, PA0);  // 19 lookup
        add(0, 0,   1, 0,  0, 1, PA0, F0, 0, PA0);  // 20 resp, handshake
        add(1, PA1, 0, 0,  1, 0, PA0, F0, 0, PA0);  // 21 accept PA1
        add(0, 0,   0, 0,  0, 0, PA0, F0, 0, PA1);  // 22 lookup
        add(0, 0,   0, 1,  0, 1, PA1, F1, 0, PA1);  // 23 flush in resp
        add(0, 0,   0, 0,  1, 0, PA1, F1, 0, PA1);  // 24 vld dropped
        add(1, PA1, 0, 0,  1, 0, PA1, F1, 0, PA1);  // 25 miss after flush
        add(0, 0,   0, 0,  0, 0, PA1, F1, 0, PA1);  // 26 lookup
        add(0, 0,   1, 0,  0, 1, PA1, F1, 0, PA1);  // 27 resp, handshake
        add(1, PA2, 0, 0,  1, 0, PA1, F1, 0, PA1);  // 28 LSB differs -> miss
        add(0, 0,   0, 0,  0, 0, PA1, F1, 0, PA2);  // 29 lookup
        add(0, 0,   0, 0,  0, 1, PA2, SYSMAP_FLG_DEFAULT, 0, PA2); // 30 resp held

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            ptw_vld = vecs[i].vld;
            ptw_ppn = vecs[i].ppn;
            tlb_rdy = vecs[i].trdy;
            flush   = vecs[i].fl;
            #1;
            chk_all(i, vecs[i].e_prdy, vecs[i].e_tvld, vecs[i].e_tppn, vecs[i].e_tflg,
                    vecs[i].e_hit, vecs[i].e_pa);
            @(posedge clk); #1;
        end

        // Reset while a response is pending
        ptw_vld = 1'b0; ptw_ppn = '0; tlb_rdy = 1'b0; flush = 1'b0;
        #1 chk("pre_rst_vld", 100, 32'(tlb_vld), 32'd1);
        #1 rst = 1'b1;
        #1 chk_all(101, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdy", 102, 32'(ptw_rdy), 32'd1);
        ptw_vld = 1'b1; ptw_ppn = PA2;
        @(posedge clk); #1;
        ptw_vld = 1'b0; ptw_ppn = '0;
        #1 chk_all(103, 1'b0, 1'b0, '0, '0, 1'b0, PA2);
        @(posedge clk); #1;
        chk_all(104, 1'b0, 1'b1, PA2, SYSMAP_FLG_DEFAULT, 1'b0, PA2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
